// File: rtl/div_chk_pkg.sv
// Shared types and constants for the divided-clock checker.
package div_chk_pkg;

  // Default width of the period / high-time counters and expectations
  localparam int DEF_CNT_W = 16;

  // Width of the tolerance input
  localparam int TOL_W = 4;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle
// rise and fall strobes derived from the synchronized value.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;

  // Shift the raw level through the synchronizer and keep a delayed copy for edge detection
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_d;
  assign fall     = ~sync_out & sync_d;

endmodule

// File: rtl/div_clock_checker.sv
// Self-check for a clock divider: samples the divided clock as data, measures
// its period and high time in source-clock cycles, flags out-of-tolerance
// periods / duty cycles and reports lock after a run of good periods.
module div_clock_checker
  import div_chk_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr_err,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [TOL_W-1:0] tol,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             err_period,
  output logic             err_duty,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR_MAX = CNT_MAX - 1'b1;
  localparam int               RUN_W        = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_TARGET  = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOCK_LAST    = RUN_W'(LOCK_COUNT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic             high_done;
  logic [RUN_W-1:0] run_cnt;

  logic             div_s;
  logic             div_rise;
  logic             div_fall;

  logic signed [CNT_W:0] p_diff;
  logic signed [CNT_W:0] h_diff;
  logic        [CNT_W:0] p_abs;
  logic        [CNT_W:0] h_abs;
  logic        [CNT_W:0] tol_ext;
  logic                  period_bad;
  logic                  duty_bad;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .d_in     (div_in),
    .sync_out (div_s),
    .rise     (div_rise),
    .fall     (div_fall)
  );

  // Compare the running counts against the expectations; one extra bit keeps the difference from wrapping
  always_comb begin
    p_diff     = $signed({1'b0, cnt}) - $signed({1'b0, exp_period});
    h_diff     = $signed({1'b0, hcnt}) - $signed({1'b0, exp_high});
    p_abs      = p_diff[CNT_W] ? $unsigned(-p_diff) : $unsigned(p_diff);
    h_abs      = h_diff[CNT_W] ? $unsigned(-h_diff) : $unsigned(h_diff);
    tol_ext    = {{(CNT_W + 1 - TOL_W){1'b0}}, tol};
    period_bad = (p_abs > tol_ext);
    duty_bad   = (h_abs > tol_ext);
  end

  // Measurement FSM with counters, sticky error flags and lock run counter; a later set overrides an earlier clear
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      high_done  <= 1'b0;
      run_cnt    <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      err_period <= 1'b0;
      err_duty   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (clr_err) begin
        err_period <= 1'b0;
        err_duty   <= 1'b0;
      end

      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        hcnt      <= '0;
        high_done <= 1'b0;
        run_cnt   <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_RISE;
          end

          WAIT_RISE: begin
            if (div_rise) begin
              state     <= MEASURE;
              cnt       <= CNT_W'(1);
              hcnt      <= CNT_W'(1);
              high_done <= 1'b0;
            end
          end

          MEASURE: begin
            if (div_rise) begin
              period_out <= cnt;
              high_out   <= hcnt;
              meas_valid <= 1'b1;
              cnt        <= CNT_W'(1);
              hcnt       <= CNT_W'(1);
              high_done  <= 1'b0;

              if (period_bad) begin
                err_period <= 1'b1;
              end
              if (duty_bad) begin
                err_duty <= 1'b1;
              end

              if (period_bad || duty_bad) begin
                run_cnt <= '0;
                locked  <= 1'b0;
              end else begin
                if (run_cnt < LOCK_TARGET) begin
                  run_cnt <= run_cnt + 1'b1;
                end
                if (run_cnt >= LOCK_LAST) begin
                  locked <= 1'b1;
                end
              end
            end else begin
              if (cnt >= CNT_NEAR_MAX) begin
                cnt        <= CNT_MAX;
                err_period <= 1'b1;
                run_cnt    <= '0;
                locked     <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end

              if (div_s && !high_done && (hcnt != CNT_MAX)) begin
                hcnt <= hcnt + 1'b1;
              end

              if (div_fall) begin
                high_done <= 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_clock_checker.sv
// Testbench for div_clock_checker: table-driven divided-clock patterns with a
// scoreboard of expected measurements, plus hand sequences for disable,
// async reset, clear/set collision and counter saturation (8-bit instance).
module tb_div_clock_checker;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        clr_err;
  logic        div_in;
  logic [15:0] exp_period;
  logic [15:0] exp_high;
  logic [3:0]  tol;
  logic [15:0] period_out;
  logic [15:0] high_out;
  logic        meas_valid;
  logic        err_period;
  logic        err_duty;
  logic        locked;

  logic        sm_enable;
  logic        sm_clr_err;
  logic        sm_div_in;
  logic [7:0]  sm_exp_period;
  logic [7:0]  sm_exp_high;
  logic [3:0]  sm_tol;
  logic [7:0]  sm_period_out;
  logic [7:0]  sm_high_out;
  logic        sm_meas_valid;
  logic        sm_err_period;
  logic        sm_err_duty;
  logic        sm_locked;

  typedef struct {
    int period;
    int high;
    int exp_p;
    int exp_h;
    int tol_v;
    int num;
    int clr;
    int err_p;
    int err_d;
    int lock;
  } vec_t;

  typedef struct {
    int period;
    int high;
    bit bad_p;
    bit bad_d;
  } sb_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  bit prev_v = 1'b0;
  int cur_p  = 0;
  int cur_h  = 0;
  int m_run  = 0;
  bit m_err_p = 1'b0;
  bit m_err_d = 1'b0;
  int sm_mv_count = 0;
  bit sm_seen;

  always #5 clk_in = ~clk_in;

  div_clock_checker #(
    .CNT_W       (16),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (4)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .clr_err    (clr_err),
    .div_in     (div_in),
    .exp_period (exp_period),
    .exp_high   (exp_high),
    .tol        (tol),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .err_period (err_period),
    .err_duty   (err_duty),
    .locked     (locked)
  );

  div_clock_checker #(
    .CNT_W       (8),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (4)
  ) dut_small (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (sm_enable),
    .clr_err    (sm_clr_err),
    .div_in     (sm_div_in),
    .exp_period (sm_exp_period),
    .exp_high   (sm_exp_high),
    .tol        (sm_tol),
    .period_out (sm_period_out),
    .high_out   (sm_high_out),
    .meas_valid (sm_meas_valid),
    .err_period (sm_err_period),
    .err_duty   (sm_err_duty),
    .locked     (sm_locked)
  );

  // One comparison: count it, and report it when it does not match
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Drive div_in for one source cycle and track the bench's own view of period/high time;
  // every rise after the arming one closes a period and pushes its expected measurement
  task automatic driveCycle(input bit v, input bit clr);
    sb_t e;
    int  dp;
    int  dh;
    @(posedge clk_in);
    #1;
    div_in  = v;
    clr_err = clr;
    if (clr) begin
      m_err_p = 1'b0;
      m_err_d = 1'b0;
    end
    if (v && !prev_v) begin
      if (armed) begin
        dp = cur_p - int'(exp_period);
        dh = cur_h - int'(exp_high);
        if (dp < 0) dp = -dp;
        if (dh < 0) dh = -dh;
        e.period = cur_p;
        e.high   = cur_h;
        e.bad_p  = (dp > int'(tol));
        e.bad_d  = (dh > int'(tol));
        sbq.push_back(e);
      end
      armed = enable;
      cur_p = 1;
      cur_h = 1;
    end else begin
      cur_p++;
      if (v) cur_h++;
    end
    prev_v = v;
  endtask

  // A run of identical periods: high for 'high' cycles, then low
  task automatic genPeriods(input int period, input int high, input int num);
    for (int p = 0; p < num; p++) begin
      for (int c = 0; c < period; c++) begin
        driveCycle(c < high, 1'b0);
      end
    end
  endtask

  // Apply one table row: program expectations, optionally clear errors on the first cycle, then check final flags
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_period = 16'(v.exp_p);
    exp_high   = 16'(v.exp_h);
    tol        = 4'(v.tol_v);
    for (int p = 0; p < v.num; p++) begin
      for (int c = 0; c < v.period; c++) begin
        driveCycle(c < v.high, (p == 0) && (c == 0) && (v.clr != 0));
        if ((p == 0) && (c == 1) && (v.clr != 0)) begin
          checkOutput($sformatf("vec%0d_clr_next_err_period", idx), int'(err_period), 0);
          checkOutput($sformatf("vec%0d_clr_next_err_duty", idx), int'(err_duty), 0);
        end
      end
    end
    checkOutput($sformatf("vec%0d_err_period", idx), int'(err_period), v.err_p);
    checkOutput($sformatf("vec%0d_err_duty", idx), int'(err_duty), v.err_d);
    checkOutput($sformatf("vec%0d_locked", idx), int'(locked), v.lock);
  endtask

  // Scoreboard: every meas_valid must match the oldest expected period, and the flag model follows it
  always @(negedge clk_in) begin
    if (reset && meas_valid) begin
      checkOutput("sb_expected_meas", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        if (mon_e.bad_p) m_err_p = 1'b1;
        if (mon_e.bad_d) m_err_d = 1'b1;
        if (mon_e.bad_p || mon_e.bad_d) begin
          m_run = 0;
        end else if (m_run < 4) begin
          m_run++;
        end
        checkOutput("sb_period_out", int'(period_out), mon_e.period);
        checkOutput("sb_high_out", int'(high_out), mon_e.high);
        checkOutput("sb_err_period", int'(err_period), int'(m_err_p));
        checkOutput("sb_err_duty", int'(err_duty), int'(m_err_d));
        checkOutput("sb_locked", int'(locked), int'(m_run >= 4));
      end
    end
    if (reset && sm_meas_valid) begin
      sm_mv_count++;
    end
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual still running, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{6, 3, 6, 3, 0, 6, 0, 0, 0, 1};
    vecs[1] = '{7, 3, 6, 3, 0, 3, 0, 1, 0, 0};
    vecs[2] = '{7, 3, 6, 3, 1, 6, 1, 0, 0, 1};
    vecs[3] = '{6, 3, 6, 3, 1, 2, 0, 0, 0, 1};
    vecs[4] = '{6, 4, 6, 3, 0, 3, 0, 0, 1, 0};
    vecs[5] = '{6, 3, 6, 3, 1, 6, 1, 0, 0, 1};

    reset         = 1'b0;
    enable        = 1'b0;
    clr_err       = 1'b0;
    div_in        = 1'b0;
    exp_period    = 16'd6;
    exp_high      = 16'd3;
    tol           = 4'd0;
    sm_enable     = 1'b0;
    sm_clr_err    = 1'b0;
    sm_div_in     = 1'b0;
    sm_exp_period = 8'd6;
    sm_exp_high   = 8'd3;
    sm_tol        = 4'd0;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("rst_period_out", int'(period_out), 0);
    checkOutput("rst_high_out", int'(high_out), 0);
    checkOutput("rst_meas_valid", int'(meas_valid), 0);
    checkOutput("rst_err_period", int'(err_period), 0);
    checkOutput("rst_err_duty", int'(err_duty), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_sm_err_period", int'(sm_err_period), 0);

    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) driveCycle(1'b0, 1'b0);

    // Table of steady patterns: nominal, long period, tolerance, duty error, clear
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Disable mid-period: IDLE next cycle, lock dropped, last measurement held
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b0, 1'b0);
    driveCycle(1'b0, 1'b0);
    checkOutput("pre_disable_locked", int'(locked), 1);
    enable = 1'b0;
    armed  = 1'b0;
    m_run  = 0;
    driveCycle(1'b0, 1'b0);
    checkOutput("disable_locked", int'(locked), 0);
    checkOutput("disable_meas_valid", int'(meas_valid), 0);
    checkOutput("disable_period_out_hold", int'(period_out), 6);
    checkOutput("disable_high_out_hold", int'(high_out), 3);
    enable = 1'b1;
    repeat (3) driveCycle(1'b0, 1'b0);
    genPeriods(6, 3, 6);
    checkOutput("reenable_locked", int'(locked), 1);
    checkOutput("reenable_period_out", int'(period_out), 6);

    // Async reset in the middle of a measurement clears outputs without waiting for a clock
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b0);
    #2;
    reset  = 1'b0;
    div_in = 1'b0;
    prev_v = 1'b0;
    armed  = 1'b0;
    sbq.delete();
    m_run   = 0;
    m_err_p = 1'b0;
    m_err_d = 1'b0;
    #1;
    checkOutput("async_rst_period_out", int'(period_out), 0);
    checkOutput("async_rst_high_out", int'(high_out), 0);
    checkOutput("async_rst_meas_valid", int'(meas_valid), 0);
    checkOutput("async_rst_err_period", int'(err_period), 0);
    checkOutput("async_rst_err_duty", int'(err_duty), 0);
    checkOutput("async_rst_locked", int'(locked), 0);
    @(posedge clk_in);
    #1;
    reset = 1'b1;

    // Clear and a failing check on the same edge: the new error survives
    exp_period = 16'd6;
    exp_high   = 16'd3;
    tol        = 4'd0;
    repeat (3) driveCycle(1'b0, 1'b0);
    genPeriods(6, 3, 2);
    genPeriods(7, 3, 1);
    checkOutput("pre_collision_err_period", int'(err_period), 0);
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b1);
    driveCycle(1'b0, 1'b0);
    repeat (3) driveCycle(1'b0, 1'b0);
    checkOutput("collision_err_period", int'(err_period), 1);
    checkOutput("collision_err_duty", int'(err_duty), 0);
    checkOutput("collision_locked", int'(locked), 0);

    // 8-bit instance: div_in stuck high saturates the period counter
    sm_enable = 1'b1;
    repeat (4) begin
      @(posedge clk_in);
      #1;
      sm_div_in = 1'b0;
    end
    @(posedge clk_in);
    #1;
    sm_div_in = 1'b1;
    repeat (100) @(posedge clk_in);
    #1;
    checkOutput("sm_no_early_saturation", int'(sm_err_period), 0);
    repeat (200) @(posedge clk_in);
    #1;
    checkOutput("sm_sat_err_period", int'(sm_err_period), 1);
    checkOutput("sm_sat_locked", int'(sm_locked), 0);
    checkOutput("sm_sat_no_meas_valid", sm_mv_count, 0);
    checkOutput("sm_sat_period_out", int'(sm_period_out), 0);
    repeat (5) begin
      @(posedge clk_in);
      #1;
      sm_div_in = 1'b0;
    end
    @(posedge clk_in);
    #1;
    sm_div_in = 1'b1;
    sm_seen   = 1'b0;
    for (int i = 0; (i < 10) && !sm_seen; i++) begin
      @(negedge clk_in);
      if (sm_meas_valid) sm_seen = 1'b1;
    end
    checkOutput("sm_meas_after_stuck", int'(sm_seen), 1);
    checkOutput("sm_period_out_saturated", int'(sm_period_out), 255);
    checkOutput("sm_high_out_saturated", int'(sm_high_out), 255);
    checkOutput("sm_err_duty", int'(sm_err_duty), 1);

    // Every expected measurement must have been produced
    repeat (5) driveCycle(1'b0, 1'b0);
    checkOutput("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
